// File: rtl/sort_rr_out_arbiter_pkg.sv
// Shared types and constants for the sort-channel output arbiter.
// Build option: define SORT_ARB_BURST_EN to allow up to BURST_MAX beats per grant.
package sort_arb_pkg;

  localparam int N_CH_DEF     = 8;
  localparam int DATASIZE_DEF = 40;

  // Arbiter FSM: IDLE picks a new owner, GRANT lets the owner move beats.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int PTR_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_rr_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning
// ptr, ptr+1, ... wrapping modulo N_CH. Returns the one-hot winner and its index.
module rr_pick
  import sort_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int PW   = PTR_W(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            any
);

  // Scan from the pointer; the first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any && req[idx]) begin
        any      = 1'b1;
        win[idx] = 1'b1;
        win_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/sort_rr_out_arbiter.sv
// Round-robin valid/ready scheduler that shares one registered output slot
// between N_CH sort channels.
// Build option: SORT_ARB_BURST_EN -- when defined, an owner keeps the grant for
// up to BURST_MAX beats; when undefined every accepted beat releases the grant.
//
// Handshake: a beat moves from channel i when req_valid[i] & req_ready[i] at a
// rising edge; it leaves the output slot when out_valid & out_ready at a rising
// edge. req_valid/out_valid never depend on the matching ready. req_ready is
// combinational from registered state plus out_ready, so the slot accepts a new
// beat in the same cycle the old one is taken downstream.
module sort_rr_out_arbiter
  import sort_arb_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int DATASIZE  = DATASIZE_DEF,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*DATASIZE-1:0] req_data,
  output logic [N_CH-1:0]          req_ready,
  output logic [DATASIZE-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH-1:0]          grant,
  output logic                     dbg_state,
  output logic [PTR_W(N_CH)-1:0]   dbg_ptr
);

  localparam int PW = PTR_W(N_CH);

  // Reject a burst length the 8-bit beat counter cannot represent.
  if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_burst_max_range
    $error("sort_rr_out_arbiter: BURST_MAX must be 1..255");
  end

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       owner_idx;
  logic [N_CH-1:0]     pick_win;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;
  logic                slot_free;
  logic                xfer;
  logic                owner_valid;
  logic [DATASIZE-1:0] owner_data;
  logic [PW-1:0]       ptr_after;
  logic                last_beat;
  logic                release_now;

  rr_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign slot_free   = !out_valid || out_ready;
  assign req_ready   = (state == GRANT && slot_free) ? grant : '0;
  assign xfer        = |(req_valid & req_ready);
  assign owner_valid = req_valid[owner_idx];
  assign owner_data  = req_data[int'(owner_idx)*DATASIZE +: DATASIZE];
  assign ptr_after   = (owner_idx == PW'(N_CH-1)) ? '0 : owner_idx + 1'b1;

`ifdef SORT_ARB_BURST_EN
  logic [7:0] beat_cnt;
  assign last_beat = ({1'b0, beat_cnt} + 9'd1) == 9'(BURST_MAX);
`else
  assign last_beat = 1'b1;
`endif

  // Backpressure alone never releases: only a final beat or a withdrawn request.
  assign release_now = (xfer && last_beat) || (!xfer && !owner_valid);

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

  // Arbitration FSM: grant, owner index, round-robin pointer and beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      owner_idx <= '0;
`ifdef SORT_ARB_BURST_EN
      beat_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_win;
            owner_idx <= pick_idx;
`ifdef SORT_ARB_BURST_EN
            beat_cnt  <= '0;
`endif
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant <= '0;
            ptr   <= ptr_after;
            state <= IDLE;
          end
`ifdef SORT_ARB_BURST_EN
          else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
`endif
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output slot: load on transfer, empty when taken, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= owner_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_rr_out_arbiter.sv
// Directed bench for sort_rr_out_arbiter with a scoreboard-checked output.
module tb_sort_rr_out_arbiter;

  localparam int N  = 8;
  localparam int DW = 40;
`ifdef SORT_ARB_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif
  // Grant period for a single-beat source: grant cycles plus the bubble.
  localparam int P = (BL == 1) ? 2 : 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            dbg_state;
  logic [2:0]      dbg_ptr;

  sort_rr_out_arbiter #(
    .N_CH      (N),
    .DATASIZE  (DW),
    .BURST_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  logic [DW-1:0] src_q[N][$];
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  acc;
  logic          hold;
  logic [DW-1:0] held;
  int            checks;
  int            errors;

  function automatic logic [DW-1:0] beat(input int ch, input int seq);
    return {8'(ch), 16'h5A00, 16'(seq)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src_q[i][0];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d, input bit expect_out);
    src_q[ch].push_back(d);
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    out_ready = 1'b1;
    refresh();
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_grant", grant, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ptr", dbg_ptr, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] g, input int budget);
    int n;
    n = 0;
    while (grant !== g && n < budget) begin
      step();
      n++;
    end
    check(name, grant, g);
  endtask

  // Sources: a beat accepted at an edge is popped just after that edge.
  initial begin
    acc = '0;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      refresh();
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        check("req_ready_outside_grant", req_ready & ~grant, 0);
        if (hold && out_valid) check("out_data_stable", out_data, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat got=%0h want=none at %0t", out_data, $time);
          end else begin
            check("scoreboard_beat", out_data, exp_q.pop_front());
          end
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [N-1:0] g;
    int           n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;

    // Single request on ch3.
    do_reset();
    push(3, 40'hA5, 1'b1);
    refresh();
    step();
    check("t1_grant", grant, 8'h08);
    check("t1_req_ready", req_ready, 8'h08);
    step();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 40'hA5);
    step();
    check("t1_released", grant, 0);
    check("t1_ptr", dbg_ptr, 4);
    wait_drain("t1_drain", 20);

    // All channels, one beat each: ch0..ch7 in order with a bubble between.
    do_reset();
    for (int ch = 0; ch < N; ch++) push(ch, beat(ch, 0), 1'b1);
    refresh();
    for (int c = 1; c <= 8 * P; c++) begin
      step();
      g = (((c - 1) % P) < (P - 1)) ? N'(1 << ((c - 1) / P)) : '0;
      check("t2_grant_seq", grant, g);
    end
    check("t2_ptr_end", dbg_ptr, 0);
    wait_drain("t2_drain", 20);

    // ch1 stream stalled downstream for 5 cycles after its first beat.
    do_reset();
    for (int s = 0; s < 4; s++) push(1, beat(1, s), 1'b1);
    refresh();
    step();
    check("t3_grant", grant, 8'h02);
    step();
    check("t3_first_valid", out_valid, 1);
    check("t3_first_data", out_data, beat(1, 0));
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_stall_valid", out_valid, 1);
      check("t3_stall_data", out_data, beat(1, 0));
      check("t3_stall_ready", req_ready, 0);
      check("t3_stall_grant", grant, 8'h02);
    end
    out_ready = 1'b1;
    wait_drain("t3_drain", 40);

    // ch0 and ch5 streaming: alternate in runs of the burst limit.
    do_reset();
    for (int s = 0; s < 8; s++) begin
      push(0, beat(0, s), 1'b0);
      push(5, beat(5, s), 1'b0);
    end
    for (int r = 0; r < 8; r += BL) begin
      for (int b = 0; b < BL; b++) exp_q.push_back(beat(0, r + b));
      for (int b = 0; b < BL; b++) exp_q.push_back(beat(5, r + b));
    end
    refresh();
    wait_drain("t45_drain", 100);

    // Reset while ch2 holds a beat in the output slot.
    do_reset();
    push(2, beat(2, 0), 1'b0);
    for (int s = 1; s < 6; s++) push(2, beat(2, s), 1'b1);
    refresh();
    step();
    check("t6_grant", grant, 8'h04);
    step();
    check("t6_slot_valid", out_valid, 1);
    check("t6_slot_data", out_data, beat(2, 0));
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_ptr", dbg_ptr, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check("t6_regrant", grant, 8'h04);
    wait_drain("t6_drain", 60);

    // ch6 withdraws while granted; its re-request then loses to ch7 and ch0.
    do_reset();
    push(5, beat(5, 0), 1'b1);
    refresh();
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("t7_ch5_out", out_valid, 1);
    out_ready = 1'b0;
    push(6, beat(6, 0), 1'b0);
    refresh();
    wait_grant("t7_grant6", 8'h40, 10);
    check("t7_ready_blocked", req_ready, 0);
    src_q[6].delete();
    refresh();
    step();
    check("t7_release", grant, 0);
    check("t7_ptr", dbg_ptr, 7);
    push(6, beat(6, 1), 1'b0);
    push(7, beat(7, 0), 1'b0);
    push(0, beat(0, 0), 1'b0);
    exp_q.push_back(beat(7, 0));
    exp_q.push_back(beat(0, 0));
    exp_q.push_back(beat(6, 1));
    refresh();
    out_ready = 1'b1;
    step();
    check("t7_grant7", grant, 8'h80);
    wait_drain("t7_drain", 40);

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
